// File: rtl/vga_pkg.sv
// Shared timing constants, counter width and prefetch state encoding for the
// 640x480@60 scan path.
package vga_pkg;
    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Inclusive sync windows for the default mode (656..751, 490..491).
    localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
    localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

    typedef enum logic {IDLE, REQ} fetch_state_t;
endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter 0..MAX for one scan axis; tc flags the last count so the next
// axis (or the fetch deadline) can key off the wrap.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int MAX = H_TOTAL - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX);

    assign tc = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= tc ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: h/v counters, registered sync/display/coordinate
// outputs, and a per-line prefetch request with deadline-based underrun flag.
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic             h_sync,
    output logic             v_sync,
    output logic             display,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             frame_start,
    output logic             fetch_req,
    output logic [CNT_W-1:0] fetch_line,
    input  logic             fetch_ack,
    output logic             underrun,
    input  logic             underrun_clr
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_LO    = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_LO    = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LASTVIS = CNT_W'(V_ACTIVE - 1);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_tc, v_tc;

    vga_axis_counter #(.MAX(H_TOT - 1)) u_h_cnt (
        .clk(clk), .rst(rst), .clr(!enable), .inc(1'b1), .cnt(h_cnt), .tc(h_tc)
    );

    vga_axis_counter #(.MAX(V_TOT - 1)) u_v_cnt (
        .clk(clk), .rst(rst), .clr(!enable), .inc(h_tc), .cnt(v_cnt), .tc(v_tc)
    );

    logic vis;
    assign vis = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    // Every scan output is registered off the same counter state, so all pins
    // share one cycle of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || !enable) begin
            h_sync      <= 1'b1;
            v_sync      <= 1'b1;
            display     <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            h_sync      <= !((h_cnt >= HS_LO) && (h_cnt < HS_HI));
            v_sync      <= !((v_cnt >= VS_LO) && (v_cnt < VS_HI));
            display     <= vis;
            x           <= vis ? h_cnt : '0;
            y           <= vis ? v_cnt : '0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    // The last line of the frame prefetches line 0 for the next frame.
    logic             has_target;
    logic [CNT_W-1:0] target;
    assign has_target = (v_cnt < V_LASTVIS) || v_tc;
    assign target     = v_tc ? '0 : v_cnt + 1'b1;

    fetch_state_t state, state_next;
    logic         load_line, underrun_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fetch_line <= '0;
            underrun   <= 1'b0;
        end else begin
            state <= state_next;
            if (load_line)         fetch_line <= target;
            if (underrun_set)      underrun   <= 1'b1;
            else if (underrun_clr) underrun   <= 1'b0;
        end
    end

    // Deadline is the h wrap; an ack landing on that same cycle still counts.
    always_comb begin
        state_next   = state;
        load_line    = 1'b0;
        underrun_set = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (h_cnt == H_ACT && has_target) begin
                    state_next = REQ;
                    load_line  = 1'b1;
                end
                REQ: if (fetch_ack) begin
                    state_next = IDLE;
                end else if (h_tc) begin
                    state_next   = IDLE;
                    underrun_set = 1'b1;
                end
            endcase
        end
    end

    assign fetch_req = (state == REQ);
endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Central scan controller for the 640x480@60 Hz VGA path, running on the 25 MHz pixel clock. It owns the horizontal and vertical counters and emits the sync pulses, display enable and pixel coordinates. It also schedules line-buffer prefetches, raising a request for the next visible line during horizontal blanking with a req/ack handshake, and flags underruns.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch

Ports:
- clk  in  1  25 MHz pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  1 = scan runs; 0 = counters held at 0,0
- h_sync  out  1  horizontal sync, active-low
- v_sync  out  1  vertical sync, active-low
- display  out  1  high while in the visible region
- x  out  10  current pixel column (valid when display=1)
- y  out  10  current line (valid when display=1)
- frame_start  out  1  one-cycle pulse at the first pixel of a frame
- fetch_req  out  1  line-buffer fetch request
- fetch_line  out  10  line index requested; stable while fetch_req=1
- fetch_ack  in  1  fetch completed; sampled only while fetch_req=1
- underrun  out  1  sticky: a fetch missed its deadline
- underrun_clr  in  1  clears underrun

## Operation
- Derived totals: H_TOTAL = 800, V_TOTAL = 525.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1.
- Region order on each axis: active, front porch, sync, back porch.
  - Horizontal sync asserts (low) for h_cnt 656..751.
  - Vertical sync asserts (low) for v_cnt 490..491.
- display = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE). While display=1, x = h_cnt and y = v_cnt. Otherwise x and y are 0.
- frame_start = (h_cnt == 0 && v_cnt == 0 && enable).
- enable = 0: both counters forced to 0 and held there; outputs take their idle values (syncs 1, display 0); any pending fetch is dropped without setting underrun. When enable returns to 1, the frame restarts at 0,0.
- Prefetch FSM states:
  - IDLE: on h_cnt == H_ACTIVE of line v, go to REQ if a target exists. Target = v+1 when v+1 < V_ACTIVE; target = 0 when v == V_TOTAL-1. Lines with no target stay in IDLE.
  - REQ: fetch_req = 1 and fetch_line = target. Go to IDLE on fetch_ack.
  - Deadline: the next h_cnt wrap to 0. If the FSM is still in REQ at the deadline, set underrun, drop fetch_req and go to IDLE.
  - Ack on the deadline cycle: the ack wins and underrun is not set.
- underrun:
  - Set has priority over underrun_clr in the same cycle.
  - underrun_clr with no set pending clears it on the next edge.

## Timing
- All outputs are registered. Each output reflects the counter state of the previous cycle, so latency from counter to pin is 1 cycle and is uniform across all outputs, keeping them mutually aligned.
- Reset values:
  - h_cnt = 0, v_cnt = 0
  - h_sync = 1, v_sync = 1
  - display = 0, x = 0, y = 0
  - frame_start = 0
  - fetch_req = 0, fetch_line = 0, underrun = 0
  - FSM in IDLE
- Reset mid-frame or mid-request returns every output to its reset value asynchronously. The scan resumes at 0,0 on the first edge after rst falls.
- fetch_req rises 1 cycle after h_cnt == 640, stays high until the edge after fetch_ack = 1, and drops 1 cycle after the wrap if no ack arrives.
- fetch_line changes only when fetch_req rises.

## Structure
- Package vga_pkg holds:
  - the default timing constants and the derived H_TOTAL/V_TOTAL
  - the counter width (10)
  - the sync start/end positions
  - the prefetch FSM state enum (IDLE, REQ)
- Sub-module vga_axis_counter: parameterised wrap counter with an increment enable and a terminal-count output. It is instantiated twice: horizontal (always enabled) and vertical (enabled by the horizontal terminal count).

## Test plan
- Reset then enable=1 for 2 frames: h_sync low for exactly 96 clocks per line starting at h_cnt=656; v_sync low for 2 lines starting at line 490; 525×800 = 420000 clocks between frame_start pulses.
- fetch_ack 5 cycles after every fetch_req: 480 requests per frame; fetch_line sequence runs 1..479, then 0 on line 524; underrun stays 0.
- No fetch_ack on line 10: fetch_req drops at the wrap into line 11 and underrun = 1. Then underrun_clr = 1 → underrun = 0 on the next edge.
- fetch_ack asserted exactly on the deadline cycle: no underrun, FSM returns to IDLE.
- Assert rst while fetch_req is high at line 200: all outputs return to their reset values immediately; after release, frame_start pulses on the first pixel.
- enable = 0 for 1000 cycles mid-frame: display = 0, syncs = 1, no fetch_req, underrun unchanged; when re-enabled, frame_start fires.
